ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Refresh scheduler for the 4-digit multiplexed seven-segment display on the lab board. It time-shares the common segment lines between the four anodes, inserts an anti-ghosting blank gap between digits, decodes hex nibbles to segments, and accepts new 4-digit frames from a producer over a valid/ready handshake. New frames are double-buffered and take effect only on frame boundaries, so a frame never tears.

## Interface
- DIGIT_CYCLES, 1000: cycles each digit is driven; must be >= 1.
- BLANK_CYCLES, 16: cycles all anodes are off before each digit; must be >= 1.
- CNT_W, 16: phase counter width; must hold max(DIGIT_CYCLES, BLANK_CYCLES) - 1.
- i_w_clk  in  1  clock; all state changes on the rising edge.
- i_w_reset_n  in  1  reset, asynchronous, active-low.
- i_w_en  in  1  scan enable; low blanks the display.
- i_w_data  in  16  four hex nibbles; digit k = [4k+3:4k]; digit 0 is AN0, the rightmost digit.
- i_w_dp  in  4  decimal point per digit, 1 = lit.
- i_w_valid  in  1  producer offers i_w_data/i_w_dp.
- o_w_ready  out  1  pending buffer empty; transfer when valid && ready.
- o_r_AN0..o_r_AN3  out  1 each  anode enables, active-low.
- o_r_CA..o_r_CG, o_r_DP  out  1 each  segments a..g and dp, active-low.
- o_r_frame_done  out  1  one-cycle pulse at the end of each completed digit-3 drive slot.

## Operation
- State machine: S_OFF, S_BLANK, S_DRIVE. Digit index 0..3 (2 bits). Phase counter CNT_W bits.
- S_OFF: all AN/segment outputs 1. Index and counter 0. Leave to S_BLANK when i_w_en = 1.
- S_BLANK: all AN = 1, segments = 1. After BLANK_CYCLES cycles -> S_DRIVE, same index.
- S_DRIVE: AN[index] = 0, others 1. Segments = decode(active nibble[index]), o_r_DP = ~active_dp[index]. After DIGIT_CYCLES cycles -> S_BLANK with index+1 mod 4. Leaving index 3 is the frame boundary.
- i_w_en = 0 in any state -> S_OFF at the next edge. Any partial frame is abandoned with no o_r_frame_done.
- Decode, with CA..CG listed a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111.
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Buffers: active (data, dp) and pending (data, dp, valid). o_w_ready = ~pending_valid.
- On a transfer, pending is loaded and pending_valid is set.
- At a frame boundary, or on any cycle in S_OFF, with pending_valid set: pending is copied to active and pending_valid is cleared.
- A transfer on a boundary cycle while pending was empty lands in pending and is displayed from the next frame.

## Timing
- Reset values:
  - all AN, segment and DP outputs 1; o_r_frame_done 0; o_w_ready 1.
  - active data 0x0000, dp 0000; pending empty; state S_OFF.
- Outputs are registered. A state or index change at edge N is visible on the outputs after edge N.
- Frame period is 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles. Sequence per frame: digits 0, 1, 2, 3.
- The first i_w_en = 1 sampled at edge N gives S_BLANK digit 0 after edge N+1.
- o_r_frame_done is high for exactly the one cycle following the S_DRIVE(3) -> S_BLANK(0) transition edge. The active-buffer swap occurs on that same edge.
- o_w_ready returns high on the cycle after a swap.
- Reset assertion mid-frame forces the reset values immediately, independent of the clock.

## Configuration
- SSD_LZ_SUPPRESS_EN defined: leading-zero suppression. During its S_DRIVE slot, digit k (k = 1..3) keeps AN high if:
  - its nibble and all higher nibbles are 0, and
  - its dp bit and all higher dp bits are 0.
- Digit 0 is never suppressed. Slot timing is unchanged.
- SSD_LZ_SUPPRESS_EN undefined: all four digits are always driven, e.g. 0x0042 displays "0042".

## Test plan
- Use DIGIT_CYCLES=4, BLANK_CYCLES=2 for all scenarios.
- Reset, then en=1 with no load: AN0..AN3 each low for 4 cycles, separated by 2-cycle all-high gaps, showing "0000" (CG=1 only). o_r_frame_done pulses every 24 cycles.
- Load data=0x1A3F, dp=0100 mid-frame: ready drops the next cycle. The current frame still shows 0000. The next frame shows AN0=F (0111000), AN1=3, AN2=A with DP=0, AN3=1. Ready rises the cycle after the frame_done swap.
- Hold valid with a second frame while pending is full: no transfer until the swap. The second frame appears exactly one frame after the first.
- Drop en during digit 2 drive: all outputs 1 the next cycle, no frame_done. Re-raise en: scan restarts at a digit 0 blank gap.
- Assert reset_n=0 asynchronously mid-drive: outputs go high and ready goes 1 without a clock edge. With SSD_LZ_SUPPRESS_EN and data 0x0042, AN3 and AN2 stay high in their slots.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
// ssd_scan_ctrl
// ----------------------------------------------------------------------------
// Refresh scheduler for a 4-digit multiplexed seven-segment display.
//
// The four anodes share one set of segment lines. Each digit is driven for
// DIGIT_CYCLES cycles. Before each digit there is an all-off gap of
// BLANK_CYCLES cycles, which prevents ghosting. Hex nibbles are decoded to
// active-low segment patterns.
//
// New 4-digit frames arrive over a valid/ready handshake into a pending
// buffer. The pending buffer is copied to the active buffer only on a frame
// boundary (the end of the digit-3 drive slot) or while the scanner is off.
// Because of this, a frame on the display never tears.
//
// Parameters
//   DIGIT_CYCLES  cycles each digit is driven (>= 1)
//   BLANK_CYCLES  all-anodes-off cycles before each digit (>= 1)
//   CNT_W         phase counter width; holds max(DIGIT,BLANK)-1
//
// Ports
//   i_w_clk         clock, rising edge
//   i_w_reset_n     asynchronous active-low reset
//   i_w_en          scan enable; low blanks the display
//   i_w_data[15:0]  four hex nibbles, digit k = [4k+3:4k], digit 0 = AN0
//   i_w_dp[3:0]     decimal point per digit, 1 = lit
//   i_w_valid       producer offers data/dp
//   o_w_ready       pending buffer empty; transfer on valid && ready
//   o_r_AN0..AN3    anode enables, active-low
//   o_r_CA..CG      segments a..g, active-low
//   o_r_DP          decimal point segment, active-low
//   o_r_frame_done  one-cycle pulse after each completed digit-3 drive slot
//
// Optional feature
//   SSD_LZ_SUPPRESS_EN  when defined, leading zeros are suppressed. Digit k
//                       (k = 1..3) keeps its anode off if it and every higher
//                       digit has a zero nibble and a clear dp bit. Digit 0
//                       is always shown. Slot timing does not change.
// ============================================================================
module ssd_scan_ctrl #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset_n,
    input  logic        i_w_en,
    input  logic [15:0] i_w_data,
    input  logic [3:0]  i_w_dp,
    input  logic        i_w_valid,
    output logic        o_w_ready,
    output logic        o_r_AN0,
    output logic        o_r_AN1,
    output logic        o_r_AN2,
    output logic        o_r_AN3,
    output logic        o_r_CA,
    output logic        o_r_CB,
    output logic        o_r_CC,
    output logic        o_r_CD,
    output logic        o_r_CE,
    output logic        o_r_CF,
    output logic        o_r_CG,
    output logic        o_r_DP,
    output logic        o_r_frame_done
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    // Segment pattern, bit 6 = a ... bit 0 = g, active-low.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q;           // i_w_en seen on the previous edge

    logic [15:0]      active_data_q, active_data_d;
    logic [3:0]       active_dp_q, active_dp_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_valid_q, pend_valid_d;

    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q;

    logic             boundary;       // this edge ends the digit-3 drive slot
    logic             swap;
    logic             xfer;

    // ------------------------------------------------------------------------
    // Scan sequencing
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        case (state_q)
            S_OFF: begin
                idx_d = 2'd0;
                cnt_d = '0;
                // Requiring en on two consecutive edges means the first
                // blank gap starts one edge after en is first seen.
                if (i_w_en && en_q) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt_q == DIGIT_LAST) begin
                    state_d  = S_BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
        // Disable wins from any state; a partial frame is dropped without
        // a frame_done pulse.
        if (!i_w_en) begin
            state_d  = S_OFF;
            idx_d    = 2'd0;
            cnt_d    = '0;
            boundary = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Double buffering
    // ------------------------------------------------------------------------
    // A transfer needs the pending buffer empty, and a swap needs it full.
    // The two therefore never happen on the same edge.
    assign xfer = i_w_valid && !pend_valid_q;
    assign swap = pend_valid_q && ((state_q == S_OFF) || boundary);

    always_comb begin
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        if (swap) begin
            active_data_d = pend_data_q;
            active_dp_d   = pend_dp_q;
            pend_valid_d  = 1'b0;
        end
        if (xfer) begin
            pend_data_d  = i_w_data;
            pend_dp_d    = i_w_dp;
            pend_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-digit views of the next active buffer
    // ------------------------------------------------------------------------
    logic [3:0] nib [4];
    logic [3:0] suppress;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = active_data_d[4*gi +: 4];
        end
    endgenerate

`ifdef SSD_LZ_SUPPRESS_EN
    // blank_from[k]: digit k and every digit above it is a plain zero.
    logic [4:0] blank_from;
    assign blank_from[4] = 1'b1;
    generate
        for (genvar gi = 3; gi >= 0; gi--) begin : g_lz
            assign blank_from[gi] = blank_from[gi+1] &&
                                    (nib[gi] == 4'h0) && !active_dp_d[gi];
        end
    endgenerate
    assign suppress = {blank_from[3:1], 1'b0};
`else
    assign suppress = 4'b0000;
`endif

    // ------------------------------------------------------------------------
    // Output drive, computed from the next state so that every output
    // register changes on the same edge as the state.
    // ------------------------------------------------------------------------
    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == S_DRIVE) begin
            seg_d = decode(nib[idx_d]);
            dp_d  = !active_dp_d[idx_d];
            if (!suppress[idx_d]) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            state_q       <= S_OFF;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            en_q          <= 1'b0;
            active_data_q <= 16'h0000;
            active_dp_q   <= 4'b0000;
            pend_data_q   <= 16'h0000;
            pend_dp_q     <= 4'b0000;
            pend_valid_q  <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            en_q          <= i_w_en;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= boundary;
        end
    end

    assign o_w_ready      = !pend_valid_q;
    assign o_r_AN0        = an_q[0];
    assign o_r_AN1        = an_q[1];
    assign o_r_AN2        = an_q[2];
    assign o_r_AN3        = an_q[3];
    assign o_r_CA         = seg_q[6];
    assign o_r_CB         = seg_q[5];
    assign o_r_CC         = seg_q[4];
    assign o_r_CD         = seg_q[3];
    assign o_r_CE         = seg_q[2];
    assign o_r_CF         = seg_q[1];
    assign o_r_CG         = seg_q[0];
    assign o_r_DP         = dp_q;
    assign o_r_frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// ============================================================================
// tb_ssd_scan_ctrl
// Self-checking bench for ssd_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2.
// The reference model tracks only "scanning or not", the position inside
// the 24-cycle frame and the two buffers. The expected outputs are derived
// from the frame position by arithmetic.
// ============================================================================
module tb_ssd_scan_ctrl;

    localparam int D     = 4;
    localparam int B     = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = 4 * SLOT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [15:0] data  = 16'h0;
    logic [3:0]  dpin  = 4'h0;
    logic        valid = 1'b0;

    logic        ready;
    logic        an0, an1, an2, an3;
    logic        ca, cb, cc, cd, ce, cf, cg, dpo;
    logic        fd;

    ssd_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B), .CNT_W(16)) dut (
        .i_w_clk(clk), .i_w_reset_n(rst_n), .i_w_en(en),
        .i_w_data(data), .i_w_dp(dpin), .i_w_valid(valid),
        .o_w_ready(ready),
        .o_r_AN0(an0), .o_r_AN1(an1), .o_r_AN2(an2), .o_r_AN3(an3),
        .o_r_CA(ca), .o_r_CB(cb), .o_r_CC(cc), .o_r_CD(cd),
        .o_r_CE(ce), .o_r_CF(cf), .o_r_CG(cg), .o_r_DP(dpo),
        .o_r_frame_done(fd)
    );

    always #5 clk = ~clk;

    wire [3:0] an  = {an3, an2, an1, an0};
    wire [6:0] seg = {ca, cb, cc, cd, ce, cf, cg};

    int checks = 0;
    int errors = 0;

    // Segment patterns a..g, active-low, indexed by nibble value.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit          m_run    = 0;
    int          m_pos    = 0;
    bit          m_enprev = 0;
    bit          m_pv     = 0;
    logic [15:0] m_pdata  = 0;
    logic [3:0]  m_pdp    = 0;
    logic [15:0] m_adata  = 0;
    logic [3:0]  m_adp    = 0;
    logic [3:0]  e_an     = 4'hF;
    logic [6:0]  e_seg    = 7'h7F;
    logic        e_dp     = 1'b1;
    logic        e_fd     = 1'b0;

    function automatic bit lz_hidden(input int dig, input logic [15:0] d, input logic [3:0] p);
`ifdef SSD_LZ_SUPPRESS_EN
        return (dig >= 1) && ((d >> (4 * dig)) == 0) && ((p >> dig) == 0);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 0; m_pos = 0; m_enprev = 0; m_pv = 0;
                m_pdata = 0; m_pdp = 0; m_adata = 0; m_adp = 0;
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            end else begin
                bit run0, pv0, bnd, swp, xfr;
                int dig, off;
                run0 = m_run;
                pv0  = m_pv;
                bnd  = run0 && en && (m_pos == FRAME - 1);
                swp  = pv0 && (!run0 || bnd);
                xfr  = valid && !pv0;
                if (swp) begin
                    m_adata = m_pdata; m_adp = m_pdp; m_pv = 0;
                end
                if (xfr) begin
                    m_pdata = data; m_pdp = dpin; m_pv = 1;
                end
                if (!en) begin
                    m_run = 0;
                end else if (!m_run) begin
                    if (m_enprev) begin
                        m_run = 1; m_pos = 0;
                    end
                end else begin
                    m_pos = (m_pos + 1) % FRAME;
                end
                m_enprev = en;
                e_fd  = bnd;
                e_an  = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
                if (m_run) begin
                    dig = m_pos / SLOT;
                    off = m_pos % SLOT;
                    if (off >= B) begin
                        e_seg = seg_tab[(m_adata >> (4 * dig)) & 16'hF];
                        e_dp  = !m_adp[dig];
                        if (!lz_hidden(dig, m_adata, m_adp))
                            e_an = ~(4'b0001 << dig);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------- per-cycle compare
    initial begin
        forever begin
            @(negedge clk);
            check("an", an, e_an);
            check("seg", seg, e_seg);
            check("dp", dpo, e_dp);
            check("frame_done", fd, e_fd);
            check("ready", ready, !m_pv);
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic wait_an(input logic [3:0] target, input string name);
        int n = 0;
        while (an != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({"wait_", name}, an, target);
    endtask

    task automatic wait_fd();
        int n = 0;
        while (fd !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_done", fd, 1);
    endtask

    initial begin
        int pulses;
        int n;
        repeat (3) @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_ready", ready, 1);
        rst_n = 1'b1;

        // Scanning with the power-on frame: "0000".
        @(negedge clk); en = 1'b1;
        wait_an(4'b1110, "an0_zero");
        check("zero_seg", seg, 7'b0000001);
        check("zero_dp", dpo, 1);
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (fd) pulses++;
        end
        check("fd_pulses_2frames", pulses, 2);

        // Load 0x1A3F with dp on digit 2, away from a frame boundary.
        wait_an(4'b1101, "an1_before_load");
        data = 16'h1A3F; dpin = 4'b0100; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        check("ready_drop", ready, 0);
        wait_fd();
        check("ready_after_swap", ready, 1);
        wait_an(4'b1110, "an0_F");
        check("F_seg", seg, 7'b0111000);
        wait_an(4'b1011, "an2_A");
        check("A_seg", seg, 7'b0001000);
        check("A_dp", dpo, 0);
        wait_an(4'b0111, "an3_1");
        check("1_seg", seg, 7'b1001111);

        // Two frames back to back; the second waits in valid until the swap.
        wait_an(4'b1101, "an1_before_pair");
        data = 16'h1234; dpin = 4'b0001; valid = 1'b1;
        @(negedge clk);
        data = 16'h5678; dpin = 4'b1000;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pair_ready_bound", ready, 1);
        @(negedge clk); valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 99) < 97);
            valid = ($urandom_range(0, 3) == 0);
            data  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            dpin  = 4'($urandom);
            if ($urandom_range(0, 1) == 0) dpin = 4'b0000;
        end
        valid = 1'b0; en = 1'b1;

        // Drop enable during the digit-2 drive slot.
        wait_an(4'b1011, "an2_before_drop");
        en = 1'b0;
        @(negedge clk);
        check("drop_an", an, 4'hF);
        check("drop_seg", seg, 7'h7F);
        check("drop_fd", fd, 0);
        en = 1'b1;
        n = 0;
        while (an == 4'hF && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("restart_digit0", an, 4'b1110);

        // Show 0x0042, then park another frame in pending and reset mid-drive.
        data = 16'h0042; dpin = 4'b0000; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        wait_fd();
        data = 16'h9999; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        check("pending_full", ready, 0);
        for (int i = 0; i < FRAME; i++) @(negedge clk);
        wait_an(4'b1110, "an0_before_reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dpo, 1);
        check("async_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        data = 16'h0042; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
